pakout: RTL

- Upstream neighbour of the packet-input stage: takes whole messages (src, dst, dat, red) on a message channel, buffers them in a small FIFO, and serialises each into fixed-width packets on a packet channel.
- The packet-input stage reassembles those packets into messages.
- Packet count per message and bit order match that stage exactly, so the two form a loopback pair.

---
 rtl/pakout_pkg.sv | 60 ++++++
 rtl/pakout_fifo.sv | 52 +++++
 rtl/pakout.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pakout_pkg.sv
// pakout_pkg: message/packet sizes, FSM encoding and red-field helper shared by pakout.
// Sizes follow the NS_* macros when defined; NS_PAKOUT_RED_GEN_EN is consumed by pakout.sv.
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 4
`endif
`ifndef NS_PACKOUT_FSZ
`define NS_PACKOUT_FSZ 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 1
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 1
`endif

package pakout_pkg;

  localparam int PSZ     = `NS_PACKET_SIZE;
  localparam int FSZ     = `NS_PACKOUT_FSZ;
  localparam int ASZ     = `NS_ADDRESS_SIZE;
  localparam int DSZ     = `NS_DATA_SIZE;
  localparam int RSZ     = `NS_REDUN_SIZE;
  localparam int FMS     = 2 * ASZ + DSZ + RSZ;
  localparam int TOT_PKS = FMS / PSZ + 1;
  // The shift register carries the message plus the zero pad below bit 0.
  localparam int SRW     = TOT_PKS * PSZ;
  localparam int PAD     = SRW - FMS;
  localparam int IDXW    = $clog2(TOT_PKS + 1);

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_s;

  typedef enum logic [2:0] {
    PK_IDLE     = 3'd0,
    PK_LOAD     = 3'd1,
    PK_SEND     = 3'd2,
    PK_WAIT_ACK = 3'd3,
    PK_WAIT_REL = 3'd4
  } pk_state_e;

  function automatic logic [RSZ-1:0] red_gen(input logic [ASZ-1:0] src,
                                             input logic [ASZ-1:0] dst,
                                             input logic [DSZ-1:0] dat);
    return RSZ'(src) + RSZ'(dst) + RSZ'(dat);
  endfunction

endpackage

// File: rtl/pakout_fifo.sv
// pakout_fifo: message FIFO with push/pop/full/empty; DEPTH must be a power of two
// so the pointers wrap naturally, and the count resolves full versus empty.
module pakout_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  // NOTE: storage is deliberately not reset; validity lives in the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pakout.sv
// pakout: accepts whole messages, buffers them, and serialises each MSB-first into packets.
// Optional NS_PAKOUT_RED_GEN_EN replaces the incoming red field with (src+dst+dat) mod 2^RSZ.
module pakout
  import pakout_pkg::*;
#(
  parameter int RCV_REQ_CKS = `NS_REQ_CKS,
  parameter int SND_ACK_CKS = `NS_ACK_CKS
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  output logic [PSZ-1:0] snd0_pakio,
  output logic           snd0_req,
  input  logic           snd0_ack
);

  localparam int RQW = $clog2(RCV_REQ_CKS + 1);
  localparam int AKW = $clog2(SND_ACK_CKS + 1);

  logic           rdy_q, clr;
  logic           req_db_q, req_ok_q, ack_db_q, ack_ok_q;
  logic [RQW-1:0] req_cnt_q;
  logic [AKW-1:0] ack_cnt_q;
  logic           rcv_ack_q, rcv_ack_d, push, pop;
  logic           fifo_full, fifo_empty;
  logic [FMS-1:0] fifo_rdata;
  msg_s           wmsg;
  pk_state_e      state_q, state_d;
  logic [SRW-1:0] sh_q, sh_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic           snd_req_q, snd_req_d;
  logic [PSZ-1:0] pakio_q, pakio_d;
  logic           last_pk;

  // The cycle after reset releases is an init cycle: everything clears once more.
  always_ff @(posedge gch_clk) begin
    if (gch_reset) rdy_q <= 1'b0;
    else           rdy_q <= 1'b1;
  end
  assign clr       = gch_reset || !rdy_q;
  assign gch_ready = rdy_q && req_ok_q && ack_ok_q;

  // A line change is accepted only after it persists for *_CKS cycles; a channel
  // counts as ready once its line has been seen at rest after reset.
  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      req_db_q  <= 1'b0;
      req_cnt_q <= '0;
      req_ok_q  <= 1'b0;
    end else begin
      if (!rcv0_req && !req_db_q) req_ok_q <= 1'b1;
      if (rcv0_req == req_db_q) begin
        req_cnt_q <= '0;
      end else if (req_cnt_q == RQW'(RCV_REQ_CKS - 1)) begin
        req_db_q  <= rcv0_req;
        req_cnt_q <= '0;
      end else begin
        req_cnt_q <= req_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      ack_db_q  <= 1'b0;
      ack_cnt_q <= '0;
      ack_ok_q  <= 1'b0;
    end else begin
      if (!snd0_ack && !ack_db_q) ack_ok_q <= 1'b1;
      if (snd0_ack == ack_db_q) begin
        ack_cnt_q <= '0;
      end else if (ack_cnt_q == AKW'(SND_ACK_CKS - 1)) begin
        ack_db_q  <= snd0_ack;
        ack_cnt_q <= '0;
      end else begin
        ack_cnt_q <= ack_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    wmsg.src = rcv0_src;
    wmsg.dst = rcv0_dst;
    wmsg.dat = rcv0_dat;
`ifdef NS_PAKOUT_RED_GEN_EN
    wmsg.red = red_gen(rcv0_src, rcv0_dst, rcv0_dat);
`else
    wmsg.red = rcv0_red;
`endif
  end

  always_comb begin
    push      = 1'b0;
    rcv_ack_d = rcv_ack_q;
    if (rdy_q && req_db_q && !rcv_ack_q && !fifo_full) begin
      push      = 1'b1;
      rcv_ack_d = 1'b1;
    end else if (!req_db_q && rcv_ack_q) begin
      rcv_ack_d = 1'b0;
    end
  end

  always_ff @(posedge gch_clk) begin
    if (clr) rcv_ack_q <= 1'b0;
    else     rcv_ack_q <= rcv_ack_d;
  end
  assign rcv0_ack = rcv_ack_q;

  pakout_fifo #(
    .W     (FMS),
    .DEPTH (FSZ)
  ) u_fifo (
    .clk     (gch_clk),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wmsg),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign last_pk = (idx_q == IDXW'(TOT_PKS - 1));

  always_ff @(posedge gch_clk) begin
    if (clr) state_q <= PK_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PK_IDLE:     if (!fifo_empty) state_d = PK_LOAD;
      PK_LOAD:     state_d = PK_SEND;
      PK_SEND:     state_d = PK_WAIT_ACK;
      PK_WAIT_ACK: if (ack_db_q) state_d = PK_WAIT_REL;
      PK_WAIT_REL: if (!ack_db_q) state_d = last_pk ? PK_IDLE : PK_SEND;
      default:     state_d = PK_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    sh_d      = sh_q;
    idx_d     = idx_q;
    snd_req_d = snd_req_q;
    pakio_d   = pakio_q;
    case (state_q)
      PK_LOAD: begin
        pop   = 1'b1;
        sh_d  = {fifo_rdata, {PAD{1'b0}}};
        idx_d = '0;
      end
      PK_SEND: begin
        pakio_d   = sh_q[SRW-1 -: PSZ];
        snd_req_d = 1'b1;
      end
      PK_WAIT_ACK: if (ack_db_q) snd_req_d = 1'b0;
      PK_WAIT_REL: begin
        if (!ack_db_q) begin
          idx_d = idx_q + 1'b1;
          sh_d  = sh_q << PSZ;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge gch_clk) begin
    if (clr) begin
      sh_q      <= '0;
      idx_q     <= '0;
      snd_req_q <= 1'b0;
      pakio_q   <= '0;
    end else begin
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      snd_req_q <= snd_req_d;
      pakio_q   <= pakio_d;
    end
  end

  assign snd0_req   = snd_req_q;
  assign snd0_pakio = pakio_q;

endmodule
